mux_sync_rx: RTL and testbench

//  Receive end of the toggle-request mux-synchronizer data crossing. Synchronizes
//  a sender-domain request toggle into clk, captures the sender's held data bus

---
 rtl/mux_sync_rx.sv | 174 +++++++++++++++++
 tb/tb_mux_sync_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sync_rx.sv
// -----------------------------------------------------------------------------
// mux_sync_rx
// Receive end of a toggle-request mux-synchronizer crossing. The sender flips
// req_tgl_a once per word and holds data_a stable until it sees ack_tgl flip.
// This block synchronizes the toggle into clk and detects its edge. On that
// edge it captures data_a through a recirculating hold mux. It then offers the
// word on a valid/ready interface and flips ack_tgl when the word is accepted.
//
// Parameters
//   DW           data bus width
//   SYNC_STAGES  flops in the req_tgl_a synchronizer chain (>= 2)
//
// Ports
//   clk          in   destination-domain clock
//   rstn         in   synchronous active-low reset
//   req_tgl_a    in   asynchronous request toggle from the sender
//   data_a       in   asynchronous data, held by the sender until ack
//   ack_tgl      out  ack toggle back to the sender, flips once per accept
//   out_valid    out  out_data holds a word that has not been accepted
//   out_data     out  captured word
//   out_ready    in   downstream accepts when out_valid & out_ready
//   busy         out  a word is held (state != IDLE)
//   err_overrun  out  sticky: a request edge arrived while a word was held
//   par_a        in   (MUX_SYNC_RX_PARITY_EN only) even parity of data_a
//   err_parity   out  (MUX_SYNC_RX_PARITY_EN only) parity error of held word
//
// Optional feature macro: MUX_SYNC_RX_PARITY_EN
// -----------------------------------------------------------------------------
module mux_sync_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_tgl_a,
    input  logic [DW-1:0] data_a,
    output logic          ack_tgl,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          err_overrun
`ifdef MUX_SYNC_RX_PARITY_EN
    ,
    input  logic          par_a,
    output logic          err_parity
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_d;
    state_t                 r_state;
    logic                   r_valid;
    logic [DW-1:0]          r_data;
    logic                   r_ack;
    logic                   r_ovr;
    logic                   r_busy;

    logic                   w_req_s;
    logic                   w_edge;
    state_t                 w_state_nxt;
    logic                   w_valid_nxt;
    logic [DW-1:0]          w_data_nxt;
    logic                   w_ack_nxt;
    logic                   w_ovr_nxt;

`ifdef MUX_SYNC_RX_PARITY_EN
    logic                   r_perr;
    logic                   w_perr_nxt;

    // Even parity over data plus parity bit; a 1 means the word is corrupt.
    function automatic logic even_par_err(input logic [DW-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    // Either polarity of the synchronized toggle marks exactly one new word.
    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_req_s ^ r_req_d;

    // Next-state and next-output decode for the capture/hold FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_ack_nxt   = r_ack;
        w_ovr_nxt   = r_ovr;
`ifdef MUX_SYNC_RX_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    // data_a is stable here: the sender holds it until ack.
                    w_data_nxt  = data_a;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_VALID;
`ifdef MUX_SYNC_RX_PARITY_EN
                    w_perr_nxt  = even_par_err(data_a, par_a);
`endif
                end else begin
                    w_data_nxt  = r_data;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VALID: begin
                // A new request while holding a word is dropped; only flag it.
                if (w_edge) begin
                    w_ovr_nxt = 1'b1;
                end else begin
                    w_ovr_nxt = r_ovr;
                end
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = ~r_ack;
                    w_state_nxt = ST_IDLE;
`ifdef MUX_SYNC_RX_PARITY_EN
                    w_perr_nxt  = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_VALID;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Synchronizer chain, edge-detect flop, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_req_d <= 1'b0;
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= {DW{1'b0}};
            r_ack   <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef MUX_SYNC_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], req_tgl_a};
            r_req_d <= w_req_s;
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_ovr   <= w_ovr_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef MUX_SYNC_RX_PARITY_EN
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign ack_tgl     = r_ack;
    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign busy        = r_busy;
    assign err_overrun = r_ovr;
`ifdef MUX_SYNC_RX_PARITY_EN
    assign err_parity  = r_perr;
`endif

endmodule

// File: tb/tb_mux_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_mux_sync_rx
// Directed bench for mux_sync_rx. The bench acts as the sender and as the
// downstream consumer. Inputs change on the falling edge and outputs are
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_mux_sync_rx;

    logic       clk;
    logic       rstn;
    logic       req_tgl_a;
    logic [7:0] data_a;
    logic       ack_tgl;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       err_overrun;
`ifdef MUX_SYNC_RX_PARITY_EN
    logic       par_a;
    logic       err_parity;
`endif

    int   n_tot;
    int   n_bad;
    int   lat;
    logic exp_ack;

    mux_sync_rx #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_tgl_a   (req_tgl_a),
        .data_a      (data_a),
        .ack_tgl     (ack_tgl),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .err_overrun (err_overrun)
`ifdef MUX_SYNC_RX_PARITY_EN
        ,
        .par_a       (par_a),
        .err_parity  (err_parity)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid. Returns the number of falling edges waited (99 on timeout).
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                n = k;
                break;
            end
        end
        if (n == 0) n = 99;
    endtask

    // Sender presents a word and flips the request toggle.
    task automatic send(input logic [7:0] d);
        data_a    = d;
        req_tgl_a = ~req_tgl_a;
    endtask

    // Downstream accepts for one cycle, then checks the handshake result.
    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_ack   = ~exp_ack;
        chk({tag, "_vld0"}, out_valid, 1'b0);
        chk({tag, "_ack"},  ack_tgl,   exp_ack);
        chk({tag, "_busy0"}, busy,     1'b0);
    endtask

    initial begin
        n_tot     = 0;
        n_bad     = 0;
        exp_ack   = 1'b0;
        rstn      = 1'b0;
        req_tgl_a = 1'b1;
        data_a    = 8'h5A;
        out_ready = 1'b0;
`ifdef MUX_SYNC_RX_PARITY_EN
        par_a     = 1'b0;
`endif

        // 1: reset with the request already high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  out_valid,   1'b0);
        chk("rst_data", out_data,    8'h00);
        chk("rst_ack",  ack_tgl,     1'b0);
        chk("rst_busy", busy,        1'b0);
        chk("rst_ovr",  err_overrun, 1'b0);
`ifdef MUX_SYNC_RX_PARITY_EN
        chk("rst_perr", err_parity,  1'b0);
`endif
        rstn = 1'b1;
        wait_valid(lat);
        chk("rst_lat",  lat,      3);
        chk("rst_word", out_data, 8'h5A);
        chk("rst_busy1", busy,    1'b1);
        accept("rst_acc");

        // 2: single word with out_ready already high.
        send(8'hA5);
        out_ready = 1'b1;
        @(negedge clk);
        chk("sw_e1_vld", out_valid, 1'b0);
        @(negedge clk);
        chk("sw_e2_vld", out_valid, 1'b0);
        @(negedge clk);
        chk("sw_e3_vld",  out_valid, 1'b1);
        chk("sw_e3_data", out_data,  8'hA5);
        chk("sw_e3_ack",  ack_tgl,   exp_ack);
        @(negedge clk);
        exp_ack = ~exp_ack;
        chk("sw_e4_vld", out_valid, 1'b0);
        chk("sw_e4_ack", ack_tgl,   exp_ack);
        out_ready = 1'b0;

        // 3: backpressure for 10 cycles.
        send(8'h3C);
        wait_valid(lat);
        chk("bp_lat", lat, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld",  out_valid, 1'b1);
            chk("bp_data", out_data,  8'h3C);
            chk("bp_ack",  ack_tgl,   exp_ack);
        end
        accept("bp_acc");

        // Back-to-back: the next edge lands in the IDLE cycle right after accept.
        send(8'h4B);
        wait_valid(lat);
        chk("b2b_first", out_data, 8'h4B);
        send(8'h77);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_ack   = ~exp_ack;
        chk("b2b_acc_vld", out_valid, 1'b0);
        chk("b2b_acc_ack", ack_tgl,   exp_ack);
        @(negedge clk);
        chk("b2b_vld",  out_valid,   1'b1);
        chk("b2b_data", out_data,    8'h77);
        chk("b2b_ovr",  err_overrun, 1'b0);
        accept("b2b_acc2");

        // 4: stream of 16 words, sender toggles on each ack.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(i[7:0]);
            wait_valid(lat);
            chk("st_lat",  lat,      3);
            chk("st_data", out_data, i);
            @(negedge clk);
            exp_ack = ~exp_ack;
            chk("st_ack", ack_tgl,   exp_ack);
            chk("st_vld", out_valid, 1'b0);
        end
        out_ready = 1'b0;
        chk("st_ovr", err_overrun, 1'b0);

        // 5: overrun with the word held.
        send(8'h11);
        wait_valid(lat);
        send(8'h22);
        repeat (5) @(negedge clk);
        chk("ov_data", out_data,    8'h11);
        chk("ov_vld",  out_valid,   1'b1);
        chk("ov_flag", err_overrun, 1'b1);
        accept("ov_acc");
        chk("ov_sticky", err_overrun, 1'b1);
        repeat (6) @(negedge clk);
        chk("ov_drop", out_valid,   1'b0);
        chk("ov_hold", err_overrun, 1'b1);
        rstn      = 1'b0;
        req_tgl_a = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        exp_ack = 1'b0;
        chk("ov_rst_flag", err_overrun, 1'b0);
        chk("ov_rst_ack",  ack_tgl,     1'b0);
        repeat (4) @(negedge clk);
        chk("ov_rst_idle", out_valid, 1'b0);

`ifdef MUX_SYNC_RX_PARITY_EN
        // 6: parity error flag travels with the word.
        par_a = 1'b0;
        send(8'h01);
        wait_valid(lat);
        chk("par_bad_data", out_data,   8'h01);
        chk("par_bad_flag", err_parity, 1'b1);
        accept("par_acc1");
        chk("par_clr", err_parity, 1'b0);
        par_a = 1'b1;
        send(8'h01);
        wait_valid(lat);
        chk("par_ok_flag", err_parity, 1'b0);
        accept("par_acc2");
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
